trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Sequencer that owns the hart privilege mode and all trap entry/exit updates to the machine CSR file.
- Arbitrates synchronous exceptions, external/timer interrupts and MRET.
- Stalls and flushes the pipeline, then drives the CSR file write port through a fixed multi-cycle write sequence.
- Finishes by issuing a single-cycle PC redirect to mtvec (trap entry) or mepc (MRET).

Parameters:
XLEN, 32, data/address width
RESET_PRIV, 2'b11, privilege mode after reset
VECTORED_EN, 1, honour mtvec MODE=1 vectoring for interrupts

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
exc_valid  input  1  synchronous exception from pipeline
exc_cause  input  4  exception code
exc_pc  input  XLEN  faulting instruction PC
exc_tval  input  XLEN  trap value (bad inst/addr)
irq_ext  input  1  external interrupt pending (level)
irq_timer  input  1  timer interrupt pending (level)
mret_req  input  1  MRET retiring
int_pc  input  XLEN  PC of next unretired instruction (mepc for interrupts)
mstatus_in  input  XLEN  current mstatus
mie_in  input  XLEN  current mie
mtvec_in  input  XLEN  current mtvec
mepc_in  input  XLEN  current mepc
csr_we  output  1  CSR write strobe
csr_waddr  output  12  CSR write address
csr_wdata  output  XLEN  CSR write data
stall  output  1  hold pipeline
flush  output  1  kill in-flight instructions
redirect_valid  output  1  PC redirect pulse
redirect_pc  output  XLEN  redirect target
priv_mode  output  2  current privilege mode

Behaviour:
- Reset (async, any state): state=IDLE, priv_mode=RESET_PRIV, all other outputs 0, latches cleared.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, M_MSTAT, REDIR.
- IDLE priority, evaluated each cycle:
  1. exc_valid.
  2. MRET in U-mode: treated as exception, cause 2, tval 0, pc=exc_pc.
  3. irq_ext if gate passes, cause 11.
  4. irq_timer if gate passes, cause 7.
  5. mret_req in M-mode.
- Interrupt gate: (priv_mode==U or mstatus_in[3]) and mie_in bit (11 ext, 7 timer).
- Accept cycle T (trap): latch cause, is_int, pc (exc_pc or int_pc), tval (0 for interrupts), old MIE, priv_mode; flush=1 for one cycle; go to W_MEPC.
- Trap writes, csr_we=1 in each:
  - T+1: 0x341 = pc & ~3.
  - T+2: 0x342 = {is_int, 27'b0, cause}.
  - T+3: 0x343 = tval.
  - T+4: 0x300 = mstatus_in with MPIE=old MIE, MIE=0, MPP=latched priv.
- T+5 REDIR: redirect_valid=1; redirect_pc = {mtvec[31:2],2'b00}. If VECTORED_EN, mtvec[1:0]==1 and is_int, target is base + 4*cause. priv_mode<=M. Next state IDLE.
- MRET accept T: flush=1; latch mepc_in and MPP.
  - T+1 M_MSTAT: 0x300 = mstatus_in with MIE=MPIE, MPIE=1, MPP=U.
  - T+2 REDIR: redirect_pc=mepc_in latched; priv_mode<=latched MPP.
- stall=1 whenever state!=IDLE, and combinationally in IDLE on the accept cycle.
- Requests arriving while not IDLE are ignored; sources re-present after redirect.
- redirect_valid is exactly one cycle. csr_we is never asserted in IDLE or REDIR.
- Simultaneous exc_valid+irq+mret: exception wins; irq is re-evaluated after return to IDLE (level inputs).
- Back-to-back: a request present in the cycle after REDIR is accepted normally.

Decomposition:
- Shared package: CSR address constants (0x300, 0x304, 0x305, 0x341–0x344), mstatus bit positions (MIE 3, MPIE 7, MPP 12:11), privilege constants (U=00, M=11), cause codes (2, 7, 11), state enum.
- Sub-module trap_prio_enc: combinational priority/gating encoder producing accept, kind, cause.

Test Plan:
- Illegal inst: exc_valid, cause 2, exc_pc=0x100, tval=0xDEADBEEF, mtvec=0x200, M-mode MIE=1 -> writes 341=0x100, 342=0x2, 343=0xDEADBEEF, 300 with MIE=0/MPIE=1/MPP=11 on T+1..T+4; redirect 0x200 at T+5.
- Timer irq: U-mode, mie[7]=1, mtvec=0x201 (vectored), int_pc=0x80 -> 342=0x80000007, 343=0, redirect 0x21C, priv=11.
- MRET: M-mode, mstatus MPIE=1 MPP=00, mepc=0x84 -> 300 write MIE=1/MPIE=1/MPP=00 at T+1; redirect 0x84 at T+2; priv=00.
- Priority: exc_valid+irq_ext+mret_req same cycle -> exception taken; after REDIR, irq_ext still high and enabled -> second trap cause 11.
- Gating: M-mode MIE=0, irq_ext=1 -> no accept, stall=0; MRET in U-mode -> cause 2 trap.
- Reset asserted at W_MCAUSE -> outputs 0 immediately, priv=RESET_PRIV; no redirect after release.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap sequencer: CSR addresses,
// mstatus field positions, privilege encodings, cause codes and FSM states.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_MTIMER  = 4'd7;
    localparam logic [3:0] CAUSE_MEXT    = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTAT,
        ST_M_MSTAT,
        ST_REDIR
    } state_e;

    // REQ_ILL_MRET is an MRET attempted from U-mode, taken as an illegal-instruction trap
    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_EXC,
        REQ_ILL_MRET,
        REQ_INT,
        REQ_MRET
    } req_kind_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational arbiter: picks the highest-priority trap/MRET request and
// applies the interrupt enable gating.
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic       exc_valid_i,
    input  logic [3:0] exc_cause_i,
    input  logic       irq_ext_i,
    input  logic       irq_timer_i,
    input  logic       mret_req_i,
    input  logic [1:0] priv_i,
    input  logic       mstatus_mie_i,
    input  logic       mie_ext_i,
    input  logic       mie_timer_i,
    output logic       accept_o,
    output req_kind_e  kind_o,
    output logic [3:0] cause_o
);

    logic int_glob_en;

    // Fixed-priority selection: exception, illegal MRET, ext irq, timer irq, MRET
    always_comb begin
        kind_o      = REQ_NONE;
        cause_o     = '0;
        int_glob_en = (priv_i == PRIV_U) || mstatus_mie_i;
        if (exc_valid_i) begin
            kind_o  = REQ_EXC;
            cause_o = exc_cause_i;
        end else if (mret_req_i && (priv_i == PRIV_U)) begin
            kind_o  = REQ_ILL_MRET;
            cause_o = CAUSE_ILLEGAL;
        end else if (irq_ext_i && int_glob_en && mie_ext_i) begin
            kind_o  = REQ_INT;
            cause_o = CAUSE_MEXT;
        end else if (irq_timer_i && int_glob_en && mie_timer_i) begin
            kind_o  = REQ_INT;
            cause_o = CAUSE_MTIMER;
        end else if (mret_req_i && (priv_i == PRIV_M)) begin
            kind_o  = REQ_MRET;
        end
        accept_o = (kind_o != REQ_NONE);
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: owns the privilege mode, stalls and flushes the
// pipeline, writes machine CSRs in a fixed sequence, then redirects the PC.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [1:0]  RESET_PRIV  = 2'b11,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            mret_req,
    input  logic [XLEN-1:0] int_pc,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mie_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv_mode
);

    state_e            state_q, state_d;
    logic [1:0]        priv_q, priv_d;
    logic [3:0]        cause_q;
    logic              is_int_q;
    logic              is_mret_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   tval_q;
    logic              old_mie_q;
    logic [1:0]        lpriv_q;

    logic              enc_accept;
    req_kind_e         enc_kind;
    logic [3:0]        enc_cause;
    logic              take;
    logic              load;
    logic [XLEN-1:0]   trap_base;
    logic              unused_mie;

    assign unused_mie = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:0]};

    trap_prio_enc u_prio (
        .exc_valid_i   (exc_valid),
        .exc_cause_i   (exc_cause),
        .irq_ext_i     (irq_ext),
        .irq_timer_i   (irq_timer),
        .mret_req_i    (mret_req),
        .priv_i        (priv_q),
        .mstatus_mie_i (mstatus_in[MSTATUS_MIE]),
        .mie_ext_i     (mie_in[11]),
        .mie_timer_i   (mie_in[7]),
        .accept_o      (enc_accept),
        .kind_o        (enc_kind),
        .cause_o       (enc_cause)
    );

    // reset also masks the combinational accept so every output reads 0 while held
    assign take      = enc_accept && !reset;
    assign load      = (state_q == ST_IDLE) && take;
    assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};
    assign priv_mode = priv_q;

    // State and privilege registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            priv_q  <= RESET_PRIV;
        end else begin
            state_q <= state_d;
            priv_q  <= priv_d;
        end
    end

    // Capture trap context on the accept cycle; pc_q holds mepc for MRET
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q   <= '0;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            pc_q      <= '0;
            tval_q    <= '0;
            old_mie_q <= 1'b0;
            lpriv_q   <= '0;
        end else if (load) begin
            cause_q   <= enc_cause;
            is_int_q  <= (enc_kind == REQ_INT);
            is_mret_q <= (enc_kind == REQ_MRET);
            pc_q      <= (enc_kind == REQ_MRET) ? mepc_in :
                         (enc_kind == REQ_INT)  ? int_pc  : exc_pc;
            tval_q    <= (enc_kind == REQ_EXC) ? exc_tval : '0;
            old_mie_q <= mstatus_in[MSTATUS_MIE];
            lpriv_q   <= (enc_kind == REQ_MRET) ? mstatus_in[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : priv_q;
        end
    end

    // Next state, CSR write port, pipeline control and redirect
    always_comb begin
        state_d        = state_q;
        priv_d         = priv_q;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    stall   = 1'b1;
                    flush   = 1'b1;
                    state_d = (enc_kind == REQ_MRET) ? ST_M_MSTAT : ST_W_MEPC;
                end
            end
            ST_W_MEPC: begin
                stall     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = {pc_q[XLEN-1:2], 2'b00};
                state_d   = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                stall             = 1'b1;
                csr_we            = 1'b1;
                csr_waddr         = CSR_MCAUSE;
                csr_wdata[XLEN-1] = is_int_q;
                csr_wdata[3:0]    = cause_q;
                state_d           = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                stall     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = tval_q;
                state_d   = ST_W_MSTAT;
            end
            ST_W_MSTAT: begin
                stall                                      = 1'b1;
                csr_we                                     = 1'b1;
                csr_waddr                                  = CSR_MSTATUS;
                csr_wdata                                  = mstatus_in;
                csr_wdata[MSTATUS_MPIE]                    = old_mie_q;
                csr_wdata[MSTATUS_MIE]                     = 1'b0;
                csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = lpriv_q;
                state_d                                    = ST_REDIR;
            end
            ST_M_MSTAT: begin
                stall                                      = 1'b1;
                csr_we                                     = 1'b1;
                csr_waddr                                  = CSR_MSTATUS;
                csr_wdata                                  = mstatus_in;
                csr_wdata[MSTATUS_MIE]                     = mstatus_in[MSTATUS_MPIE];
                csr_wdata[MSTATUS_MPIE]                    = 1'b1;
                csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = PRIV_U;
                state_d                                    = ST_REDIR;
            end
            ST_REDIR: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                if (is_mret_q) begin
                    redirect_pc = pc_q;
                    priv_d      = lpriv_q;
                end else begin
                    redirect_pc = trap_base;
                    if (VECTORED_EN && (mtvec_in[1:0] == 2'b01) && is_int_q) begin
                        redirect_pc = trap_base + XLEN'({cause_q, 2'b00});
                    end
                    priv_d = PRIV_M;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios followed by random
// requests, all checked against a transaction-level model of trap handling.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        irq_ext, irq_timer, mret_req;
    logic [31:0] int_pc, mstatus_in, mie_in, mtvec_in, mepc_in;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  priv_mode;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir;
    logic [1:0]  exp_priv;
    bit          exp_take;
    logic [1:0]  m_priv;

    trap_ctrl #(
        .XLEN        (32),
        .RESET_PRIV  (2'b11),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .mret_req       (mret_req),
        .int_pc         (int_pc),
        .mstatus_in     (mstatus_in),
        .mie_in         (mie_in),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .priv_mode      (priv_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
        irq_ext = 0; irq_timer = 0; mret_req = 0; int_pc = 0;
        mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0;
    endtask

    // Reference: what the trap architecture says happens for the current request set
    task automatic model_decide();
        bit          int_ok;
        int          cause;
        bit          is_int;
        logic [31:0] epc, tv, ms, target;
        int_ok = (m_priv == 2'b00) || (mstatus_in[3] == 1'b1);
        exp_wr.delete();
        exp_take = 1;
        if (exc_valid) begin
            cause = int'(exc_cause); is_int = 0; epc = exc_pc; tv = exc_tval;
        end else if (mret_req && m_priv == 2'b00) begin
            cause = 2; is_int = 0; epc = exc_pc; tv = 0;
        end else if (irq_ext && int_ok && mie_in[11]) begin
            cause = 11; is_int = 1; epc = int_pc; tv = 0;
        end else if (irq_timer && int_ok && mie_in[7]) begin
            cause = 7; is_int = 1; epc = int_pc; tv = 0;
        end else if (mret_req && m_priv == 2'b11) begin
            ms = mstatus_in;
            ms[3] = mstatus_in[7];
            ms[7] = 1'b1;
            ms[12:11] = 2'b00;
            exp_wr.push_back('{12'h300, ms});
            exp_redir = mepc_in;
            exp_priv  = mstatus_in[12:11];
            return;
        end else begin
            exp_take = 0;
            return;
        end
        ms = mstatus_in;
        ms[7] = mstatus_in[3];
        ms[3] = 1'b0;
        ms[12:11] = m_priv;
        exp_wr.push_back('{12'h341, epc - (epc % 4)});
        exp_wr.push_back('{12'h342, (is_int ? 32'h8000_0000 : 32'h0) + 32'(cause)});
        exp_wr.push_back('{12'h343, tv});
        exp_wr.push_back('{12'h300, ms});
        target = mtvec_in - (mtvec_in % 4);
        if (is_int && (mtvec_in % 4) == 1) target = target + 32'(4 * cause);
        exp_redir = target;
        exp_priv  = 2'b11;
    endtask

    // Called just after a negedge with the request inputs applied; returns on a later negedge
    task automatic txn(input string name, input bit keep_irq);
        #1;
        model_decide();
        if (!exp_take) begin
            chk({name, "_idle_stall"}, 32'(stall), 32'd0);
            chk({name, "_idle_flush"}, 32'(flush), 32'd0);
            chk({name, "_idle_we"}, 32'(csr_we), 32'd0);
            chk({name, "_idle_redir"}, 32'(redirect_valid), 32'd0);
            @(negedge clk);
            return;
        end
        chk({name, "_acc_stall"}, 32'(stall), 32'd1);
        chk({name, "_acc_flush"}, 32'(flush), 32'd1);
        chk({name, "_acc_we"}, 32'(csr_we), 32'd0);
        @(posedge clk);
        #1;
        exc_valid = 0;
        mret_req  = 0;
        if (!keep_irq) begin
            irq_ext   = 0;
            irq_timer = 0;
        end
        foreach (exp_wr[i]) begin
            @(negedge clk);
            chk($sformatf("%s_wr%0d_we", name, i), 32'(csr_we), 32'd1);
            chk($sformatf("%s_wr%0d_addr", name, i), 32'(csr_waddr), 32'(exp_wr[i].addr));
            chk($sformatf("%s_wr%0d_data", name, i), csr_wdata, exp_wr[i].data);
            chk($sformatf("%s_wr%0d_stall", name, i), 32'(stall), 32'd1);
            chk($sformatf("%s_wr%0d_flush", name, i), 32'(flush), 32'd0);
            chk($sformatf("%s_wr%0d_redir", name, i), 32'(redirect_valid), 32'd0);
        end
        @(negedge clk);
        chk({name, "_redir_valid"}, 32'(redirect_valid), 32'd1);
        chk({name, "_redir_pc"}, redirect_pc, exp_redir);
        chk({name, "_redir_we"}, 32'(csr_we), 32'd0);
        chk({name, "_redir_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
        chk({name, "_post_redir_valid"}, 32'(redirect_valid), 32'd0);
        chk({name, "_post_priv"}, 32'(priv_mode), 32'(exp_priv));
        m_priv = exp_priv;
    endtask

    initial begin
        clear_inputs();
        reset  = 1;
        m_priv = 2'b11;
        @(negedge clk);
        chk("rst_we", 32'(csr_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir", 32'(redirect_valid), 32'd0);
        chk("rst_priv", 32'(priv_mode), 32'd3);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Illegal instruction in M-mode with MIE=1
        mstatus_in = 32'h0000_0008; mtvec_in = 32'h200;
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD_BEEF;
        txn("illegal", 0);

        // MRET from M back to U
        clear_inputs();
        mstatus_in = 32'h0000_0080; mepc_in = 32'h84; mret_req = 1;
        txn("mret", 0);

        // Vectored timer interrupt taken from U-mode
        clear_inputs();
        mie_in = 32'h80; mtvec_in = 32'h201; int_pc = 32'h80; irq_timer = 1;
        txn("timer", 0);

        // External interrupt masked by MIE=0 in M-mode
        clear_inputs();
        mie_in = 32'h800; irq_ext = 1;
        txn("gated", 0);
        chk("gated_priv", 32'(priv_mode), 32'd3);

        // Return to U, then attempt MRET from U
        clear_inputs();
        mstatus_in = 32'h0000_0000; mepc_in = 32'h400; mret_req = 1;
        txn("mret2", 0);
        clear_inputs();
        mtvec_in = 32'h300; exc_pc = 32'h404; exc_tval = 32'h1234; mret_req = 1;
        txn("umret", 0);

        // Exception beats simultaneous irq and MRET; irq follows on return
        clear_inputs();
        mstatus_in = 32'h0000_0008; mie_in = 32'h800; mtvec_in = 32'h501; int_pc = 32'h610;
        exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h60E; exc_tval = 32'hA5A5_0000;
        irq_ext = 1; mret_req = 1;
        txn("prio_exc", 1);
        txn("prio_irq", 0);

        // Reset mid-sequence at W_MCAUSE
        clear_inputs();
        mtvec_in = 32'h200; exc_valid = 1; exc_cause = 4'd4; exc_pc = 32'h900;
        @(posedge clk);
        #1;
        exc_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        chk("midrst_we", 32'(csr_we), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_redir", 32'(redirect_valid), 32'd0);
        chk("midrst_priv", 32'(priv_mode), 32'd3);
        m_priv = 2'b11;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("postrst_redir%0d", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("postrst_we%0d", i), 32'(csr_we), 32'd0);
        end

        // Random request mixes
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ms;
            clear_inputs();
            ms = $urandom;
            ms[12:11] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            mstatus_in = ms;
            mie_in     = $urandom;
            mtvec_in   = $urandom;
            mepc_in    = $urandom;
            int_pc     = $urandom;
            exc_pc     = $urandom;
            exc_tval   = $urandom;
            exc_cause  = 4'($urandom_range(0, 15));
            exc_valid  = ($urandom_range(0, 3) == 0);
            mret_req   = ($urandom_range(0, 2) == 0);
            irq_ext    = ($urandom_range(0, 2) == 0);
            irq_timer  = ($urandom_range(0, 2) == 0);
            txn($sformatf("rnd%0d", n), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
